// File: rtl/quad_decoder.sv
// Quadrature decoder: sync + debounce both channels, emit step/err pulses.
// In: clk, rst_n, enc_a, enc_b, clear. Out: enable, countUpDown, err, err_cnt.
module quad_decoder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clear,
  output logic       enable,
  output logic       countUpDown,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic        a_m_q, a_m_d;
  logic        a_s_q, a_s_d;
  logic        b_m_q, b_m_d;
  logic        b_s_q, b_s_d;
  logic [7:0]  cnt_a_q, cnt_a_d;
  logic [7:0]  cnt_b_q, cnt_b_d;
  logic        deb_a_q, deb_a_d;
  logic        deb_b_q, deb_b_d;
  logic [1:0]  prev_q, prev_d;
  logic        enable_q, enable_d;
  logic        dir_q, dir_d;
  logic        err_q, err_d;
  logic [3:0]  err_cnt_q, err_cnt_d;

  logic [1:0]  pos_cur;
  logic [1:0]  pos_prev;
  logic [1:0]  step;

  // Gray pair {A,B} -> position along the up sequence
  // 00->0, 10->1, 11->2, 01->3; step = wrapped delta.
  assign pos_cur  = {deb_b_q, deb_a_q ^ deb_b_q};
  assign pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign step     = pos_cur - pos_prev;

  always_comb begin
    a_m_d     = enc_a;
    a_s_d     = a_m_q;
    b_m_d     = enc_b;
    b_s_d     = b_m_q;
    deb_a_d   = deb_a_q;
    deb_b_d   = deb_b_q;
    cnt_a_d   = '0;
    cnt_b_d   = '0;
    state_d   = state_q;
    wait_d    = wait_q;
    prev_d    = prev_q;
    enable_d  = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir_q;
    err_cnt_d = err_cnt_q;

    if (a_s_q != deb_a_q) begin
      if (cnt_a_q == DEB_M1) begin
        deb_a_d = a_s_q;
      end else begin
        cnt_a_d = cnt_a_q + 8'd1;
      end
    end

    if (b_s_q != deb_b_q) begin
      if (cnt_b_q == DEB_M1) begin
        deb_b_d = b_s_q;
      end else begin
        cnt_b_d = cnt_b_q + 8'd1;
      end
    end

    unique case (state_q)
      WAIT: begin
        if (wait_q) begin
          state_d = LOAD;
        end else begin
          wait_d = 1'b1;
        end
      end
      LOAD: begin
        // resting position is adopted, not decoded
        deb_a_d = a_s_q;
        deb_b_d = b_s_q;
        cnt_a_d = '0;
        cnt_b_d = '0;
        prev_d  = {a_s_q, b_s_q};
        state_d = RUN;
      end
      RUN: begin
        prev_d = {deb_a_q, deb_b_q};
        unique case (step)
          2'd1: begin
            enable_d = 1'b1;
            dir_d    = 1'b1;
          end
          2'd3: begin
            enable_d = 1'b1;
            dir_d    = 1'b0;
          end
          2'd2: begin
            err_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        state_d = WAIT;
      end
    endcase

    if (clear) begin
      err_cnt_d = '0;
    end else if (err_d && err_cnt_q != 4'hf) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT;
      wait_q    <= 1'b0;
      a_m_q     <= 1'b0;
      a_s_q     <= 1'b0;
      b_m_q     <= 1'b0;
      b_s_q     <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      deb_a_q   <= 1'b0;
      deb_b_q   <= 1'b0;
      prev_q    <= 2'b00;
      enable_q  <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      a_m_q     <= a_m_d;
      a_s_q     <= a_s_d;
      b_m_q     <= b_m_d;
      b_s_q     <= b_s_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      deb_a_q   <= deb_a_d;
      deb_b_q   <= deb_b_d;
      prev_q    <= prev_d;
      enable_q  <= enable_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enable      = enable_q;
  assign countUpDown = dir_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: random/directed rotation, scoreboard monitor.
// Expected events are queued at stimulus time and popped on each pulse.
module tb_quad_decoder;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       clear = 1'b0;
  logic       enable;
  logic       countUpDown;
  logic       err;
  logic [3:0] err_cnt;

  quad_decoder #(.DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .clear      (clear),
    .enable     (enable),
    .countUpDown(countUpDown),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    bit dir;
    int t;
  } ev_t;

  ev_t  q[$];
  ev_t  ev;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   model_dir = 1'b0;
  int   pos = 0;
  int   exp_errcnt = 0;
  logic [1:0] gray [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      model_dir = 1'b0;
      chk("reset_outputs",
          int'({enable, err, countUpDown, err_cnt}), 0);
    end else if (enable && err) begin
      chk("enable_err_exclusive", 1, 0);
    end else if (enable || err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'({enable, err}), 0);
      end else begin
        ev = q.pop_front();
        chk("event_kind_err", int'(err), int'(ev.is_err));
        chk("event_latency", cyc - ev.t, DEB + 3);
        if (!ev.is_err) begin
          chk("step_dir", int'(countUpDown), int'(ev.dir));
          model_dir = ev.dir;
        end else begin
          chk("dir_hold_on_err", int'(countUpDown),
              int'(model_dir));
        end
      end
    end else begin
      chk("dir_hold", int'(countUpDown), int'(model_dir));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
  endtask

  // Move the encoder to position np; queue what that move should yield.
  task automatic go(int np, int hold);
    int d;
    ev_t e;
    @(posedge clk);
    #1;
    {enc_a, enc_b} = gray[np];
    d = (np - pos) & 3;
    if (d != 0) begin
      e.is_err = (d == 2);
      e.dir    = (d == 1);
      e.t      = cyc;
      q.push_back(e);
      if (d == 2 && !clear && exp_errcnt < 15) exp_errcnt++;
    end
    pos = np;
    tick(hold);
  endtask

  // Glitch one channel for w consecutive clocks, then restore.
  task automatic glitch(bit on_a, int w);
    @(posedge clk);
    #1;
    if (on_a) enc_a = ~enc_a;
    else      enc_b = ~enc_b;
    tick(w);
    #1;
    if (on_a) enc_a = ~enc_a;
    else      enc_b = ~enc_b;
    tick(10);
  endtask

  task automatic do_reset(int np);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    {enc_a, enc_b} = gray[np];
    pos = np;
    exp_errcnt = 0;
    tick(3);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    gray[0] = 2'b00;
    gray[1] = 2'b10;
    gray[2] = 2'b11;
    gray[3] = 2'b01;

    do_reset(0);
    tick(5);

    // Up rotation, then down rotation
    for (int i = 0; i < 4; i++) go((pos + 1) & 3, 10);
    for (int i = 0; i < 4; i++) go((pos + 3) & 3, 10);

    // Bounce: toggle every clock for 3 clocks, then a 3-wide pulse
    @(posedge clk);
    #1 enc_a = ~enc_a;
    tick(1);
    #1 enc_a = ~enc_a;
    tick(1);
    #1 enc_a = ~enc_a;
    tick(1);
    #1 enc_a = ~enc_a;
    tick(10);
    glitch(1'b1, DEB - 1);
    glitch(1'b0, DEB - 1);

    // Rest at 11 through reset release; no events
    do_reset(2);
    tick(20);
    go(3, 10);

    // Double-bit changes: saturate err_cnt
    go(0, 10);
    for (int i = 0; i < 17; i++) begin
      go(2, 10);
      go(0, 10);
    end
    chk("err_cnt_saturated", int'(err_cnt), 15);
    chk("err_cnt_model", int'(err_cnt), exp_errcnt);

    // Clear held across an err edge: clear wins
    @(posedge clk);
    #1 clear = 1'b1;
    go(2, 10);
    #1 clear = 1'b0;
    exp_errcnt = 0;
    chk("err_cnt_clear_wins", int'(err_cnt), 0);
    go(0, 10);
    chk("err_cnt_after_clear", int'(err_cnt), 1);

    // Reset two clocks after a change, before any pulse
    @(posedge clk);
    #1 {enc_a, enc_b} = gray[1];
    tick(2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_enable", int'(enable), 0);
    chk("async_reset_err_cnt", int'(err_cnt), 0);
    pos = 1;
    exp_errcnt = 0;
    tick(3);
    #1 rst_n = 1'b1;
    tick(20);

    // Randomized walk with occasional double steps and glitches
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       go((pos + 1) & 3, $urandom_range(8, 14));
      else if (r < 8)  go((pos + 3) & 3, $urandom_range(8, 14));
      else if (r == 8) go((pos + 2) & 3, $urandom_range(8, 14));
      else glitch(1'($urandom_range(0, 1)),
                  $urandom_range(1, DEB - 1));
    end

    tick(20);
    chk("queue_drained", q.size(), 0);
    chk("err_cnt_final", int'(err_cnt), exp_errcnt);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
